// File: rtl/p2s_sched_pkg.sv
// Shared types and constants for the p2s byte-slot scheduler.
// Optional statistics are enabled with `define SCHED_STATS_EN.
package p2s_sched_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        SEND = 2'd2
    } sched_state_t;

    // Byte the serializer emits whenever valid_in is low.
    localparam logic [7:0] COMMA_BYTE = 8'hBC;
    localparam int         SLOT_LEN   = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational; the pointer lives in the parent.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Contention goes to the pointer, otherwise the lone requester wins.
    always_comb begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            gnt_id = ptr;
        end else begin
            gnt_id = req[1];
        end
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/p2s_byte_scheduler.sv
// Byte-slot scheduler for the 8:1 serializer lane in the clk_8f domain.
// Two requesters share the lane round-robin; each granted byte occupies one
// full slot. After reset a run of INIT_COMMAS comma slots is forced.
// Define SCHED_STATS_EN to add saturating grant/idle counters.
module p2s_byte_scheduler
    import p2s_sched_pkg::*;
#(
    parameter int INIT_COMMAS = 4,
    parameter int SLOT_BITS   = 3
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic       enable,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       slot_start,
    output logic       grant_id,
    output logic [1:0] state_out
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] cnt_req0,
    output logic [15:0] cnt_req1,
    output logic [15:0] cnt_idle
`endif
);

    localparam logic [SLOT_BITS-1:0] SLOT_ONE  = {{(SLOT_BITS-1){1'b0}}, 1'b1};
    localparam logic [7:0]           LAST_COMMA = 8'(INIT_COMMAS - 1);

    logic [SLOT_BITS-1:0] slot_cnt;
    logic [7:0]           comma_cnt;
    sched_state_t         state, state_nxt;
    logic                 rr_ptr;
    logic [1:0]           gnt;
    logic                 gnt_id;
    logic                 boundary;
    logic                 last_comma;
    logic                 sched_open;
    logic                 take;

    assign boundary   = (slot_cnt == {SLOT_BITS{1'b1}});
    assign last_comma = (comma_cnt == LAST_COMMA);
    // The final INIT boundary already schedules the slot that follows the
    // comma run, so traffic can start right after the last comma slot.
    assign sched_open = (state != INIT) || last_comma;
    assign take       = boundary && sched_open && enable && (gnt != 2'b00);

    assign req0_ready = take && gnt[0];
    assign req1_ready = take && gnt[1];
    assign slot_start = (slot_cnt == '0);
    assign state_out  = state;

    rr_arbiter2 u_arb (
        .req    ({req1_valid, req0_valid}),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Free-running slot counter kept in lockstep with the serializer's bit counter.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_ONE;
        end
    end

    // Counts forced comma slots while in INIT.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            comma_cnt <= 8'd0;
        end else if (boundary && state == INIT && !last_comma) begin
            comma_cnt <= comma_cnt + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision, taken only in the boundary cycle.
    always_comb begin
        state_nxt = state;
        if (boundary) begin
            case (state)
                INIT:    if (last_comma) state_nxt = take ? SEND : IDLE;
                IDLE:    state_nxt = take ? SEND : IDLE;
                SEND:    state_nxt = take ? SEND : IDLE;
                default: state_nxt = INIT;
            endcase
        end
    end

    // Serializer-facing byte: loads on a transfer, otherwise the next slot is a comma.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            grant_id  <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (boundary) begin
            if (take) begin
                data_out  <= gnt_id ? req1_data : req0_data;
                valid_out <= 1'b1;
                grant_id  <= gnt_id;
                rr_ptr    <= ~gnt_id;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef SCHED_STATS_EN
    // Saturating per-requester grant counts and idle comma-slot count.
    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            cnt_req0 <= 16'd0;
            cnt_req1 <= 16'd0;
            cnt_idle <= 16'd0;
        end else if (boundary && sched_open) begin
            if (take && !gnt_id) cnt_req0 <= sat_inc16(cnt_req0);
            if (take &&  gnt_id) cnt_req1 <= sat_inc16(cnt_req1);
            if (!take)           cnt_idle <= sat_inc16(cnt_idle);
        end
    end
`endif

endmodule

// File: tb/tb_p2s_byte_scheduler.sv
// Directed self-checking bench for p2s_byte_scheduler (INIT_COMMAS=4).
module tb_p2s_byte_scheduler;
    import p2s_sched_pkg::*;

    logic       clk_8f = 1'b0;
    logic       reset_L;
    logic       enable;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] data_out;
    logic       valid_out, slot_start, grant_id;
    logic [1:0] state_out;
`ifdef SCHED_STATS_EN
    logic [15:0] cnt_req0, cnt_req1, cnt_idle;
`endif

    int total = 0;
    int bad   = 0;
    int c     = 0;
    int r0n   = 0;
    int r1n   = 0;

    p2s_byte_scheduler #(.INIT_COMMAS(4), .SLOT_BITS(3)) dut (
        .clk_8f     (clk_8f),
        .reset_L    (reset_L),
        .enable     (enable),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .slot_start (slot_start),
        .grant_id   (grant_id),
        .state_out  (state_out)
`ifdef SCHED_STATS_EN
        ,
        .cnt_req0   (cnt_req0),
        .cnt_req1   (cnt_req1),
        .cnt_idle   (cnt_idle)
`endif
    );

    always #5 clk_8f = ~clk_8f;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to cycle 'target', counting ready pulses in every cycle passed.
    task automatic goto(input int target);
        while (c < target) begin
            if (req0_ready === 1'b1) r0n++;
            if (req1_ready === 1'b1) r1n++;
            @(negedge clk_8f);
            c++;
        end
    endtask

    function automatic logic [7:0] line_byte();
        return valid_out ? data_out : COMMA_BYTE;
    endfunction

    initial begin
        reset_L    = 1'b0;
        enable     = 1'b1;
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        req1_data  = 8'h3C;
        req1_valid = 1'b1;
        @(negedge clk_8f);
        @(negedge clk_8f);
        chk("rst_data",  16'(data_out),   16'h00);
        chk("rst_valid", 16'(valid_out),  16'h0);
        chk("rst_gid",   16'(grant_id),   16'h0);
        chk("rst_rdy",   16'({req1_ready, req0_ready}), 16'h0);
        chk("rst_slot",  16'(slot_start), 16'h1);
        chk("rst_state", 16'(state_out),  16'(INIT));

        // Release reset: cycle 0 is the first cycle with slot_cnt==0.
        reset_L = 1'b1;
        c = 0;
        chk("c0_slot", 16'(slot_start), 16'h1);
        goto(3);
        chk("c3_slot", 16'(slot_start), 16'h0);
        goto(8);
        chk("c8_slot", 16'(slot_start), 16'h1);
        r0n = 0; r1n = 0;
        goto(31);
        chk("init_no_ready", 16'(r0n + r1n), 16'd0);
        chk("c31_rdy", 16'({req1_ready, req0_ready}), 16'b01);
        chk("c31_state", 16'(state_out), 16'(INIT));
        goto(32);
        chk("c32_data", 16'(data_out), 16'hA5);
        chk("c32_valid", 16'(valid_out), 16'h1);
        chk("c32_gid", 16'(grant_id), 16'h0);
        chk("c32_state", 16'(state_out), 16'(SEND));

        // Alternation with both valid.
        goto(40);
        chk("c40_data", 16'(data_out), 16'h3C);
        chk("c40_gid",  16'(grant_id), 16'h1);
        goto(45);
        chk("c45_line", 16'(line_byte()), 16'h3C);
        goto(48);
        chk("c48_data", 16'(data_out), 16'hA5);
        r0n = 0; r1n = 0;
        goto(56);
        chk("slot_one_pulse", 16'(r0n + r1n), 16'd1);
        chk("c56_data", 16'(data_out), 16'h3C);
        req1_data = 8'h81;
        r0n = 0; r1n = 0;
        goto(64);
        chk("c64_data", 16'(data_out), 16'hA5);
        chk("c64_gid",  16'(grant_id), 16'h0);

        // Only req1 valid.
        req0_valid = 1'b0;
        goto(71);
        #1;
        chk("c71_rdy", 16'({req1_ready, req0_ready}), 16'b10);
        goto(72);
        chk("c72_data", 16'(data_out), 16'h81);
        chk("c72_gid",  16'(grant_id), 16'h1);
        goto(80);
        chk("c80_data", 16'(data_out), 16'h81);
        chk("c80_valid", 16'(valid_out), 16'h1);
        // Pointer stayed at req0, so contention now goes to req0.
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        goto(87);
        #1;
        chk("c87_rdy", 16'({req1_ready, req0_ready}), 16'b01);
        goto(88);
        chk("c88_data", 16'(data_out), 16'hA5);

        // Enable drops mid-slot: A5 completes, next slot is a comma.
        goto(91);
        enable = 1'b0;
        goto(95);
        #1;
        chk("c95_rdy", 16'({req1_ready, req0_ready}), 16'b00);
        chk("c95_valid", 16'(valid_out), 16'h1);
        chk("c95_data", 16'(data_out), 16'hA5);
        goto(96);
        chk("c96_valid", 16'(valid_out), 16'h0);
        chk("c96_data",  16'(data_out),  16'hA5);
        chk("c96_state", 16'(state_out), 16'(IDLE));
        chk("c96_line",  16'(line_byte()), 16'hBC);
        enable     = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        goto(104);
        chk("c104_valid", 16'(valid_out), 16'h0);
        chk("c104_state", 16'(state_out), 16'(IDLE));

        // Valid rising off-boundary is only seen at the next boundary.
        goto(106);
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        #1;
        chk("c106_rdy", 16'({req1_ready, req0_ready}), 16'b00);
        goto(111);
        #1;
        chk("c111_rdy", 16'({req1_ready, req0_ready}), 16'b01);
        goto(112);
        chk("c112_data",  16'(data_out),  16'h5A);
        chk("c112_state", 16'(state_out), 16'(SEND));
        req1_valid = 1'b1;
        req1_data  = 8'h3C;

        // Asynchronous reset in the middle of a SEND slot.
        goto(117);
        #1;
        reset_L = 1'b0;
        #1;
        chk("ar_data",  16'(data_out),   16'h00);
        chk("ar_valid", 16'(valid_out),  16'h0);
        chk("ar_gid",   16'(grant_id),   16'h0);
        chk("ar_state", 16'(state_out),  16'(INIT));
        chk("ar_slot",  16'(slot_start), 16'h1);
        chk("ar_rdy",   16'({req1_ready, req0_ready}), 16'b00);
        @(negedge clk_8f);
        reset_L = 1'b1;
        c = 0;
        r0n = 0; r1n = 0;
        goto(31);
        chk("reinit_no_ready", 16'(r0n + r1n), 16'd0);
        chk("re_c31_rdy", 16'({req1_ready, req0_ready}), 16'b01);
        goto(32);
        chk("re_c32_data", 16'(data_out), 16'h5A);
        chk("re_c32_gid",  16'(grant_id), 16'h0);
`ifdef SCHED_STATS_EN
        goto(33);
        chk("st_req0", cnt_req0, 16'd1);
        chk("st_req1", cnt_req1, 16'd0);
        chk("st_idle", cnt_idle, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
